// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Multi-channel push-button conditioner. Each channel is optionally inverted,
//   passed through a two-flop synchroniser, then debounced by a per-channel
//   counter. The debounced level only flips after the synchronised input has
//   disagreed with it for DEBOUNCE_CYCLES consecutive edges. Registered
//   one-cycle press/release pulses accompany each level change.
//
//   Parameters
//     N_BTN           number of independent channels (1..8)
//     DEBOUNCE_CYCLES consecutive disagreeing edges needed to flip the level (>=1)
//     ACTIVE_LOW      1 = raw pins are low when pressed
//
//   Ports
//     CLK         in   system clock, rising-edge
//     RST         in   synchronous active-high reset
//     btn_raw     in   [N_BTN] asynchronous raw pins
//     btn_level   out  [N_BTN] debounced pressed level (1 = pressed)
//     btn_press   out  [N_BTN] one-cycle pulse on debounced 0->1
//     btn_release out  [N_BTN] one-cycle pulse on debounced 1->0
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // A single-cycle debounce still needs a 1-bit counter, so clamp the width.
  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] w_raw;
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;
  logic [CNT_W-1:0] r_cnt     [N_BTN];
  logic [CNT_W-1:0] w_cnt_nxt [N_BTN];
  logic [N_BTN-1:0] w_mismatch;
  logic [N_BTN-1:0] w_toggle;
  logic [N_BTN-1:0] w_level_nxt;

  // Counter advance: agreement restarts the count; reaching the terminal
  // value also wraps to 0 because that edge flips the level instead.
  function automatic logic [CNT_W-1:0] cnt_step(input logic             mismatch,
                                                input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
    nxt = '0;
    if (mismatch && (cnt != CNT_MAX)) begin
      nxt = cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

  // Polarity normalisation happens before the synchroniser so that every
  // later stage works in "1 = pressed" terms.
  assign w_raw = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // Debounce decision, evaluated on the synchronised (stage 2) value.
  always_comb begin
    w_mismatch = '0;
    w_toggle   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_mismatch[i] = (r_sync2[i] != r_level[i]);
      w_toggle[i]   = w_mismatch[i] && (r_cnt[i] == CNT_MAX);
      w_cnt_nxt[i]  = cnt_step(w_mismatch[i], r_cnt[i]);
    end
    w_level_nxt = r_level ^ w_toggle;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      // Stage 1/2: metastability synchroniser.
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      // Stage 3: debounce counter, level and edge pulses.
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_level   <= w_level_nxt;
      // Pulses are registered with the level, so they coincide with the first
      // cycle of the new level; a toggle is either rising or falling, never both.
      r_press   <= w_toggle & w_level_nxt;
      r_release <= w_toggle & ~w_level_nxt;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//   Bench for btn_conditioner. Three instances share clock and reset:
//     dut_a : DEBOUNCE_CYCLES=4, ACTIVE_LOW=0
//     dut_b : DEBOUNCE_CYCLES=4, ACTIVE_LOW=1
//     dut_c : DEBOUNCE_CYCLES=1, ACTIVE_LOW=0
//   A hand-written vector table covers the directed scenarios, short
//   sequences cover active-low and single-cycle debounce, and a random run is
//   compared against a run-length reference model.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  logic       CLK;
  logic       RST;
  logic [2:0] raw_a, raw_b, raw_c;
  logic [2:0] lvl_a, prs_a, rel_a;
  logic [2:0] lvl_b, prs_b, rel_b;
  logic [2:0] lvl_c, prs_c, rel_c;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(.N_BTN(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)) dut_a (
    .CLK(CLK), .RST(RST), .btn_raw(raw_a),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a));

  btn_conditioner #(.N_BTN(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut_b (
    .CLK(CLK), .RST(RST), .btn_raw(raw_b),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b));

  btn_conditioner #(.N_BTN(3), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(0)) dut_c (
    .CLK(CLK), .RST(RST), .btn_raw(raw_c),
    .btn_level(lvl_c), .btn_press(prs_c), .btn_release(rel_c));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: a pressed level flips once the input seen two edges ago
  // has disagreed with it on DC consecutive edges.
  // ---------------------------------------------------------------------------
  logic [2:0] m_s1  [3];
  logic [2:0] m_s2  [3];
  logic [2:0] m_lvl [3];
  logic [2:0] m_prs [3];
  logic [2:0] m_rel [3];
  int         m_run [3][3];

  task automatic model_edge(input int m, input logic [2:0] raw, input int dc, input bit al);
    logic [2:0] nl;
    if (RST) begin
      m_s1[m] = '0; m_s2[m] = '0; m_lvl[m] = '0; m_prs[m] = '0; m_rel[m] = '0;
      for (int c = 0; c < 3; c++) m_run[m][c] = 0;
    end else begin
      nl = m_lvl[m];
      m_prs[m] = '0;
      m_rel[m] = '0;
      for (int c = 0; c < 3; c++) begin
        if (m_s2[m][c] != m_lvl[m][c]) begin
          m_run[m][c] = m_run[m][c] + 1;
          if (m_run[m][c] == dc) begin
            m_run[m][c] = 0;
            nl[c] = ~nl[c];
            if (nl[c]) m_prs[m][c] = 1'b1;
            else       m_rel[m][c] = 1'b1;
          end
        end else begin
          m_run[m][c] = 0;
        end
      end
      m_lvl[m] = nl;
      m_s2[m]  = m_s1[m];
      m_s1[m]  = al ? ~raw : raw;
    end
  endtask

  // One clock: models advance on the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    model_edge(0, raw_a, 4, 1'b0);
    model_edge(1, raw_b, 4, 1'b1);
    model_edge(2, raw_c, 1, 1'b0);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table for dut_a: inputs before an edge, outputs after it.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       rst;
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] raw, input logic [2:0] l,
                     input logic [2:0] p, input logic [2:0] rl, input int n);
    vec_t v;
    v.rst = r; v.raw = raw; v.lvl = l; v.prs = p; v.rel = rl;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  int         hold [3];
  logic [2:0] rv   [3];

  initial begin
    RST   = 1'b1;
    raw_a = 3'b000;
    raw_b = 3'b111;
    raw_c = 3'b000;
    for (int m = 0; m < 3; m++) begin
      m_s1[m] = '0; m_s2[m] = '0; m_lvl[m] = '0; m_prs[m] = '0; m_rel[m] = '0;
      for (int c = 0; c < 3; c++) m_run[m][c] = 0;
    end

    // Reset
    add(1, 3'b000, 3'b000, 3'b000, 3'b000, 2);
    // Clean press on channel 0, held (no repeat)
    add(0, 3'b001, 3'b000, 3'b000, 3'b000, 5);
    add(0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
    add(0, 3'b001, 3'b001, 3'b000, 3'b000, 4);
    // Release channel 0
    add(0, 3'b000, 3'b001, 3'b000, 3'b000, 5);
    add(0, 3'b000, 3'b000, 3'b000, 3'b001, 1);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 2);
    // Bounce on channel 1: 1,0,1,0 then held 1
    add(0, 3'b010, 3'b000, 3'b000, 3'b000, 1);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    add(0, 3'b010, 3'b000, 3'b000, 3'b000, 1);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    add(0, 3'b010, 3'b000, 3'b000, 3'b000, 5);
    add(0, 3'b010, 3'b010, 3'b010, 3'b000, 1);
    add(0, 3'b010, 3'b010, 3'b000, 3'b000, 2);
    add(0, 3'b000, 3'b010, 3'b000, 3'b000, 5);
    add(0, 3'b000, 3'b000, 3'b000, 3'b010, 1);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    // Simultaneous press on all channels
    add(0, 3'b111, 3'b000, 3'b000, 3'b000, 5);
    add(0, 3'b111, 3'b111, 3'b111, 3'b000, 1);
    add(0, 3'b111, 3'b111, 3'b000, 3'b000, 2);
    // Held through reset: treated as a new press, no pulse on deassert
    add(1, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    add(0, 3'b111, 3'b000, 3'b000, 3'b000, 5);
    add(0, 3'b111, 3'b111, 3'b111, 3'b000, 1);
    add(0, 3'b111, 3'b111, 3'b000, 3'b000, 1);
    add(0, 3'b000, 3'b111, 3'b000, 3'b000, 5);
    add(0, 3'b000, 3'b000, 3'b000, 3'b111, 1);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    // Reset on edge 4 of a press discards the partial count
    add(0, 3'b001, 3'b000, 3'b000, 3'b000, 3);
    add(1, 3'b001, 3'b000, 3'b000, 3'b000, 1);
    add(0, 3'b001, 3'b000, 3'b000, 3'b000, 5);
    add(0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
    add(0, 3'b001, 3'b001, 3'b000, 3'b000, 1);
    add(0, 3'b000, 3'b001, 3'b000, 3'b000, 5);
    add(0, 3'b000, 3'b000, 3'b000, 3'b001, 1);

    foreach (tbl[k]) begin
      RST   = tbl[k].rst;
      raw_a = tbl[k].raw;
      step();
      chk($sformatf("tbl%0d_level", k),   lvl_a, tbl[k].lvl);
      chk($sformatf("tbl%0d_press", k),   prs_a, tbl[k].prs);
      chk($sformatf("tbl%0d_release", k), rel_a, tbl[k].rel);
      // Active-low instance held at all-ones is idle throughout.
      chk($sformatf("tbl%0d_al_idle", k), lvl_b | prs_b | rel_b, 3'b000);
    end

    // Active-low: pulling pin 2 low is a press on channel 2 after 6 edges.
    raw_b = 3'b011;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("al_wait%0d_level", k), lvl_b, 3'b000);
      chk($sformatf("al_wait%0d_press", k), prs_b, 3'b000);
    end
    step();
    chk("al_edge6_level", lvl_b, 3'b100);
    chk("al_edge6_press", prs_b, 3'b100);
    step();
    chk("al_edge7_press", prs_b, 3'b000);
    chk("al_edge7_level", lvl_b, 3'b100);

    // Single-cycle debounce: level follows on edge 3 in both directions.
    raw_c = 3'b001;
    step(); chk("dc1_p_e1_level", lvl_c, 3'b000);
    step(); chk("dc1_p_e2_level", lvl_c, 3'b000);
    step(); chk("dc1_p_e3_level", lvl_c, 3'b001); chk("dc1_p_e3_press", prs_c, 3'b001);
    step(); chk("dc1_p_e4_press", prs_c, 3'b000); chk("dc1_p_e4_level", lvl_c, 3'b001);
    raw_c = 3'b000;
    step(); chk("dc1_r_e1_level", lvl_c, 3'b001);
    step(); chk("dc1_r_e2_level", lvl_c, 3'b001);
    step(); chk("dc1_r_e3_level", lvl_c, 3'b000); chk("dc1_r_e3_release", rel_c, 3'b001);
    step(); chk("dc1_r_e4_release", rel_c, 3'b000);

    // Random run against the reference model.
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int m = 0; m < 3; m++) begin
      hold[m] = 0;
      rv[m]   = 3'b000;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int m = 0; m < 3; m++) begin
        if (hold[m] == 0) begin
          rv[m]   = 3'($urandom_range(0, 7));
          hold[m] = int'($urandom_range(1, 9));
        end else begin
          hold[m] = hold[m] - 1;
        end
      end
      raw_a = rv[0];
      raw_b = rv[1];
      raw_c = rv[2];
      RST   = ($urandom_range(0, 299) == 0);
      step();
      chk($sformatf("rnd%0d_a_level", cyc),   lvl_a, m_lvl[0]);
      chk($sformatf("rnd%0d_a_press", cyc),   prs_a, m_prs[0]);
      chk($sformatf("rnd%0d_a_release", cyc), rel_a, m_rel[0]);
      chk($sformatf("rnd%0d_b_level", cyc),   lvl_b, m_lvl[1]);
      chk($sformatf("rnd%0d_b_press", cyc),   prs_b, m_prs[1]);
      chk($sformatf("rnd%0d_b_release", cyc), rel_b, m_rel[1]);
      chk($sformatf("rnd%0d_c_level", cyc),   lvl_c, m_lvl[2]);
      chk($sformatf("rnd%0d_c_press", cyc),   prs_c, m_prs[2]);
      chk($sformatf("rnd%0d_c_release", cyc), rel_c, m_rel[2]);
      chk($sformatf("rnd%0d_a_excl", cyc),    prs_a & rel_a, 3'b000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have a parameter N_BTN, default 3, giving the number of independent button channels (range 1..8).
REQ-002 The block SHALL have a parameter DEBOUNCE_CYCLES, default 12000 (1 ms at 12 MHz), giving the stable-input time in clock cycles (minimum 1).
REQ-003 The block SHALL have a parameter ACTIVE_LOW, default 0; when 1, each raw input is inverted before synchronisation.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port btn_raw, input, N_BTN bits: asynchronous raw button pins; bit i is channel i.
REQ-007 The block SHALL have port btn_level, output, N_BTN bits: debounced pressed level (1 = pressed).
REQ-008 The block SHALL have port btn_press, output, N_BTN bits: one-cycle pulse on each debounced 0->1 transition.
REQ-009 The block SHALL have port btn_release, output, N_BTN bits: one-cycle pulse on each debounced 1->0 transition.

Function
REQ-010 Each channel SHALL pass its (optionally inverted) raw input through a two-flop synchroniser (sync1, sync2) before any other use.
REQ-011 Each channel SHALL hold a counter of width max(1, ceil(log2(DEBOUNCE_CYCLES))) bits that never exceeds DEBOUNCE_CYCLES-1.
REQ-012 On an edge where sync2 equals btn_level, the counter SHALL clear to 0.
REQ-013 On an edge where sync2 differs from btn_level and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 On an edge where sync2 differs from btn_level and the counter equals DEBOUNCE_CYCLES-1, the block SHALL toggle btn_level and clear the counter.
REQ-015 Latency: a raw change held stable SHALL change btn_level on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value as edge 1.
REQ-016 The block SHALL register btn_press high for exactly the first cycle in which btn_level is newly 1, and low otherwise.
REQ-017 The block SHALL register btn_release high for exactly the first cycle in which btn_level is newly 0, and low otherwise.
REQ-018 For any channel, btn_press and btn_release SHALL never be high in the same cycle.
REQ-019 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive counting edges (glitch or bounce) SHALL NOT change btn_level; each return to agreement restarts the count from 0.
REQ-020 Channels SHALL be fully independent; simultaneous qualifying changes on several channels SHALL pulse all of them in the same cycle.
REQ-021 A button held continuously SHALL produce exactly one press pulse, with no repeat.
REQ-022 With DEBOUNCE_CYCLES = 1, the first edge with a mismatch at sync2 SHALL toggle btn_level, giving a latency of 3 edges.

Reset
REQ-023 While RST is high at a rising edge, sync1, sync2, counters, btn_level, btn_press and btn_release SHALL all become 0.
REQ-024 A reset asserted mid-count SHALL discard the partial count; counting restarts from 0 on the first edge after RST deasserts.
REQ-025 A button held pressed through reset SHALL, after RST deasserts, be treated as a new press: btn_level rises and one btn_press pulse is issued after the REQ-015 latency.
REQ-026 No output SHALL pulse in the cycle RST deasserts.

Verification (DEBOUNCE_CYCLES=4, N_BTN=3, ACTIVE_LOW=0)
REQ-027 Clean press: btn_raw[0] rises and is held -> btn_level[0] goes to 1 on edge 6; btn_press[0] is high for that one cycle only; other channels stay 0.
REQ-028 Bounce: btn_raw[1] toggles 1,0,1,0 each cycle, then holds 1 -> no pulse during the bounce; btn_level[1] rises exactly 6 edges after the final 1 is first sampled.
REQ-029 Release: channel 0 is pressed, then btn_raw[0] falls -> btn_level[0] goes to 0 on edge 6; one btn_release[0] pulse; btn_press[0] stays 0.
REQ-030 Simultaneous: btn_raw goes 3'b000 -> 3'b111 -> all three btn_press bits pulse in the same cycle, and btn_level = 3'b111.
REQ-031 Reset mid-count: RST is pulsed on edge 4 of a press -> all outputs are 0 after it; btn_level rises 6 edges after RST deasserts, with a single btn_press.
REQ-032 ACTIVE_LOW=1: btn_raw held at 3'b111 from reset -> btn_level stays 3'b000 and no pulses occur; btn_raw[2] driven to 0 -> btn_press[2] pulses after 6 edges.
